// File: rtl/glyph_row_fetcher_pkg.sv
// glyph_row_fetcher_pkg: shared widths, glyph address layout and fetch FSM states
package glyph_row_fetcher_pkg;

   localparam int CHAR_CODE_WIDTH  = 8;
   localparam int GLYPH_ROW_WIDTH  = 4;
   localparam int GLYPH_ADDR_WIDTH = 12;
   localparam int COL_WIDTH        = 7;

   typedef struct packed {
      logic [CHAR_CODE_WIDTH-1:0] code;
      logic [GLYPH_ROW_WIDTH-1:0] row;
   } glyph_addr_t;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_t;

endpackage

// File: rtl/glyph_row_fetcher_rom_arbiter.sv
// glyph_rom_arbiter: shares the character ROM port between video S1 and CPU readback
module glyph_rom_arbiter
   import glyph_row_fetcher_pkg::*;
(
   input  logic                        clk_i,
   input  logic                        reset_ni,
   input  logic                        video_valid_i,
   input  glyph_addr_t                 video_addr_i,
   input  logic                        cpu_req_i,
   input  logic [GLYPH_ADDR_WIDTH-1:0] cpu_addr_i,
   input  logic [31:0]                 rom_data_i,
   output logic [GLYPH_ADDR_WIDTH-1:0] rom_addr_o,
   output logic                        cpu_ack_o,
   output logic [31:0]                 cpu_data_o
);

   logic [GLYPH_ADDR_WIDTH-1:0] last_addr;
   logic [31:0]                 held_data;
   logic                        grant;

   // a CPU read is in flight exactly during its ack cycle, so ack doubles as the outstanding flag
   assign grant      = reset_ni & ~video_valid_i & cpu_req_i & ~cpu_ack_o;
   assign rom_addr_o = video_valid_i ? video_addr_i : grant ? cpu_addr_i : last_addr;
   assign cpu_data_o = cpu_ack_o ? rom_data_i : held_data;

   // remember the last ROM address, raise ack one cycle after grant, keep the CPU data stable
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         last_addr <= '0;
         cpu_ack_o <= 1'b0;
         held_data <= '0;
      end else begin
         last_addr <= rom_addr_o;
         cpu_ack_o <= grant;
         if (cpu_ack_o) held_data <= rom_data_i;
      end
   end

endmodule

// File: rtl/glyph_row_fetcher.sv
// glyph_row_fetcher: walks one text line per scanline through text RAM and character ROM into the line buffer
module glyph_row_fetcher
   import glyph_row_fetcher_pkg::*;
#(
   parameter int COLUMNS         = 80,
   parameter int TEXT_ADDR_WIDTH = 12
) (
   input  logic                        clk_i,
   input  logic                        reset_ni,
   input  logic                        start_i,
   input  logic                        abort_i,
   input  logic [TEXT_ADDR_WIDTH-1:0]  line_base_i,
   input  logic [GLYPH_ROW_WIDTH-1:0]  glyph_row_i,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        text_en_o,
   output logic [TEXT_ADDR_WIDTH-1:0]  text_addr_o,
   input  logic [CHAR_CODE_WIDTH-1:0]  text_data_i,
   output logic [GLYPH_ADDR_WIDTH-1:0] rom_addr_o,
   input  logic [31:0]                 rom_data_i,
   output logic                        lb_we_o,
   output logic [COL_WIDTH-1:0]        lb_addr_o,
   output logic [31:0]                 lb_data_o,
   input  logic                        cpu_req_i,
   input  logic [GLYPH_ADDR_WIDTH-1:0] cpu_addr_i,
   output logic                        cpu_ack_o,
   output logic [31:0]                 cpu_data_o
);

   localparam logic [COL_WIDTH-1:0] LAST_COL = COL_WIDTH'(COLUMNS - 1);

   fetch_state_t               state;
   logic [TEXT_ADDR_WIDTH-1:0] base;
   logic [GLYPH_ROW_WIDTH-1:0] row;
   logic [COL_WIDTH-1:0]       col, col_next, s1_col, s2_col;
   logic                       issue, s1_valid, s2_valid, s1_live;
   glyph_addr_t                video_addr;

   // abort kills the issue slot and both pipeline stages in the cycle it is seen
   assign col_next   = col + 1'b1;
   assign text_en_o  = issue & ~abort_i;
   assign s1_live    = s1_valid & ~abort_i;
   assign lb_we_o    = s2_valid & ~abort_i;
   assign lb_addr_o  = s2_col;
   assign lb_data_o  = lb_we_o ? rom_data_i : '0;
   assign video_addr = '{code: text_data_i, row: row};

   // line fetch sequencer: issue one column per cycle, then wait for the pipeline to drain
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state       <= IDLE;
         base        <= '0;
         row         <= '0;
         col         <= '0;
         issue       <= 1'b0;
         text_addr_o <= '0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: if (start_i && !abort_i) begin
               base        <= line_base_i;
               row         <= glyph_row_i;
               col         <= '0;
               text_addr_o <= line_base_i;
               issue       <= 1'b1;
               busy_o      <= 1'b1;
               state       <= FETCH;
            end
            FETCH: if (abort_i) begin
               issue  <= 1'b0;
               busy_o <= 1'b0;
               state  <= IDLE;
            end else if (col == LAST_COL) begin
               issue <= 1'b0;
               state <= DRAIN;
            end else begin
               col         <= col_next;
               text_addr_o <= base + TEXT_ADDR_WIDTH'(col_next);
            end
            DRAIN: if (abort_i) begin
               busy_o <= 1'b0;
               state  <= IDLE;
            end else if (!s1_valid) begin
               done_o <= 1'b1;
               busy_o <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // column tags ride along with the stage valids so every write carries its own column
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s1_col   <= '0;
         s2_col   <= '0;
      end else begin
         s1_valid <= text_en_o;
         s1_col   <= col;
         s2_valid <= s1_live;
         s2_col   <= s1_col;
      end
   end

   glyph_rom_arbiter u_arbiter (
      .clk_i        (clk_i),
      .reset_ni     (reset_ni),
      .video_valid_i(s1_live),
      .video_addr_i (video_addr),
      .cpu_req_i    (cpu_req_i),
      .cpu_addr_i   (cpu_addr_i),
      .rom_data_i   (rom_data_i),
      .rom_addr_o   (rom_addr_o),
      .cpu_ack_o    (cpu_ack_o),
      .cpu_data_o   (cpu_data_o)
   );

endmodule

// File: tb/tb_glyph_row_fetcher.sv
// tb_glyph_row_fetcher: scoreboard bench with text RAM and character ROM models
module tb_glyph_row_fetcher;

   localparam int COLS = 80;

   logic        clk_i = 1'b0, reset_ni = 1'b1, start_i = 1'b0, abort_i = 1'b0;
   logic [11:0] line_base_i = '0;
   logic [3:0]  glyph_row_i = '0;
   logic        busy_o, done_o, text_en_o, lb_we_o, cpu_ack_o;
   logic [11:0] text_addr_o, rom_addr_o;
   logic [7:0]  text_data_i = '0;
   logic [31:0] rom_data_i = '0, lb_data_o, cpu_data_o;
   logic [6:0]  lb_addr_o;
   logic        cpu_req_i = 1'b0;
   logic [11:0] cpu_addr_i = '0;

   glyph_row_fetcher #(.COLUMNS(COLS), .TEXT_ADDR_WIDTH(12)) dut (
      .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i), .abort_i(abort_i),
      .line_base_i(line_base_i), .glyph_row_i(glyph_row_i), .busy_o(busy_o), .done_o(done_o),
      .text_en_o(text_en_o), .text_addr_o(text_addr_o), .text_data_i(text_data_i),
      .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i), .lb_we_o(lb_we_o), .lb_addr_o(lb_addr_o),
      .lb_data_o(lb_data_o), .cpu_req_i(cpu_req_i), .cpu_addr_i(cpu_addr_i),
      .cpu_ack_o(cpu_ack_o), .cpu_data_o(cpu_data_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   function automatic logic [31:0] rom_fn(input logic [11:0] a);
      return {a, ~a, a[7:0]};
   endfunction

   // text RAM holds code = low address byte; ROM content is a fixed function of its address
   always @(posedge clk_i) begin
      if (text_en_o) text_data_i <= text_addr_o[7:0];
      rom_data_i <= rom_fn(rom_addr_o);
   end

   typedef struct {logic [6:0] col; logic [31:0] data; int cyc;} wr_t;
   typedef struct {logic [31:0] data; int cyc;} ck_t;
   wr_t wq[$];
   ck_t cq[$];
   int  dq[$];
   wr_t we;
   ck_t ce;
   int  de;
   int  vectors = 0, errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor: every line buffer write, done pulse and CPU ack is popped against the scoreboard
   always @(negedge clk_i) if (reset_ni) begin
      if (lb_we_o) begin
         if (wq.size() == 0) begin
            vectors++; errors++;
            $display("FAIL unexpected_lb_write: got col %0d expected none (cycle %0d)", lb_addr_o, cyc);
         end else begin
            we = wq.pop_front();
            check("lb_addr", lb_addr_o, we.col);
            check("lb_data", lb_data_o, we.data);
            check("lb_cycle", cyc, we.cyc);
         end
      end
      if (done_o) begin
         if (dq.size() == 0) begin
            vectors++; errors++;
            $display("FAIL unexpected_done: got pulse expected none (cycle %0d)", cyc);
         end else begin
            de = dq.pop_front();
            check("done_cycle", cyc, de);
            check("busy_at_done", busy_o, 0);
         end
      end
      if (cpu_ack_o) begin
         if (cq.size() == 0) begin
            vectors++; errors++;
            $display("FAIL unexpected_cpu_ack: got ack expected none (cycle %0d)", cyc);
         end else begin
            ce = cq.pop_front();
            check("cpu_data", cpu_data_o, ce.data);
            check("cpu_ack_cycle", cyc, ce.cyc);
         end
      end
   end

   // called 1 time unit after a rising edge; returns with the bench in cycle 1 (+nchk-1)
   task automatic start_line(input logic [11:0] base, input logic [3:0] row, input int nw,
                             input bit dn, input int nchk, output int c0);
      logic [11:0] a;
      start_i = 1'b1; line_base_i = base; glyph_row_i = row;
      c0 = cyc + 1;
      for (int k = 0; k < nw; k++) begin
         a = base + 12'(k);
         wq.push_back('{7'(k), rom_fn({a[7:0], row}), c0 + 2 + k});
      end
      if (dn) dq.push_back(c0 + COLS + 2);
      @(posedge clk_i); #1;
      start_i = 1'b0;
      check("busy_after_start", busy_o, 1);
      for (int k = 0; k < nchk; k++) begin
         a = base + 12'(k);
         check("text_addr", text_addr_o, a);
         check("text_en", text_en_o, 1);
         if (k < nchk - 1) begin @(posedge clk_i); #1; end
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300 && busy_o; i++) begin @(posedge clk_i); #1; end
      if (busy_o) begin
         vectors++; errors++;
         $display("FAIL busy_timeout: got busy expected idle (cycle %0d)", cyc);
      end
      repeat (3) @(posedge clk_i);
      #1;
      check("writes_outstanding", wq.size(), 0);
      check("done_outstanding", dq.size(), 0);
      check("acks_outstanding", cq.size(), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int c0, c;
      #2 reset_ni = 1'b0;
      @(posedge clk_i); @(posedge clk_i); #1;
      check("reset_ctrl", {busy_o, done_o, text_en_o, lb_we_o, cpu_ack_o}, 0);
      check("reset_addr", {text_addr_o, rom_addr_o, lb_addr_o}, 0);
      check("reset_data", {lb_data_o, cpu_data_o}, 0);
      reset_ni = 1'b1;
      @(posedge clk_i); #1;

      // full line: codes equal column index
      start_line(12'h100, 4'd5, COLS, 1, 3, c0);
      wait_idle();

      // base wraps past the end of text RAM
      start_line(12'hFFE, 4'd9, COLS, 1, 4, c0);
      wait_idle();

      // CPU read while idle, request held across the ack
      cpu_req_i = 1'b1; cpu_addr_i = 12'hA53;
      c = cyc;
      cq.push_back('{rom_fn(12'hA53), c + 1});
      cq.push_back('{rom_fn(12'hA53), c + 3});
      repeat (3) @(posedge clk_i);
      #1 cpu_req_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1 check("idle_acks_left", cq.size(), 0);

      // CPU contention during a fetch: first free slot is cycle 82
      start_line(12'h100, 4'd5, COLS, 1, 1, c0);
      @(posedge clk_i); #1;
      cpu_req_i = 1'b1; cpu_addr_i = 12'h3C7;
      cq.push_back('{rom_fn(12'h3C7), c0 + 82});
      for (int i = 0; i < 200 && !cpu_ack_o; i++) @(negedge clk_i);
      cpu_req_i = 1'b0;
      wait_idle();

      // abort at cycle 10: only columns 0..6 reach the line buffer
      start_line(12'h100, 4'd3, 7, 0, 1, c0);
      repeat (9) @(posedge clk_i);
      #1 abort_i = 1'b1;
      #1 check("lb_we_in_abort", lb_we_o, 0);
      @(posedge clk_i); #1;
      abort_i = 1'b0;
      check("busy_after_abort", busy_o, 0);
      check("text_en_after_abort", text_en_o, 0);
      repeat (4) @(posedge clk_i);
      #1 check("abort_writes_left", wq.size(), 0);

      // fresh line after abort
      start_line(12'h200, 4'd15, COLS, 1, 2, c0);
      wait_idle();

      // abort together with start in idle: start ignored
      start_i = 1'b1; abort_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0; abort_i = 1'b0;
      check("busy_abort_start", busy_o, 0);
      repeat (4) @(posedge clk_i);
      #1;

      // asynchronous reset in cycle 20
      start_line(12'h100, 4'd5, 17, 0, 1, c0);
      repeat (19) @(posedge clk_i);
      #1 reset_ni = 1'b0;
      #1;
      check("midreset_ctrl", {busy_o, done_o, text_en_o, lb_we_o, cpu_ack_o}, 0);
      check("midreset_addr", {text_addr_o, rom_addr_o, lb_addr_o}, 0);
      check("midreset_data", {lb_data_o, cpu_data_o}, 0);
      check("midreset_writes_left", wq.size(), 0);
      repeat (2) @(posedge clk_i);
      #1 reset_ni = 1'b1;
      @(posedge clk_i); #1;
      start_line(12'h100, 4'd5, COLS, 1, 2, c0);
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/glyph_row_fetcher.md
Name: glyph_row_fetcher

Overview:
- Sequences the character ROM for text-mode video. At the start of each scanline it walks one text line: it reads COLUMNS character codes from text RAM, looks up each code's glyph row in the character ROM, and writes the 32-pixel rows into a line buffer.
- It owns the single ROM read port. Idle ROM slots are shared with a CPU glyph-readback requester.
- Sits between the text RAM, character_rom and the scanline buffer feeding the pixel serializer.

Parameters:
- COLUMNS, 80, characters fetched per line (1..127).
- TEXT_ADDR_WIDTH, 12, text RAM address width.

Ports:
- clk_i  in  1  system clock
- reset_ni  in  1  asynchronous active-low reset
- start_i  in  1  begin line fetch (sampled only when busy_o=0)
- abort_i  in  1  cancel fetch in progress
- line_base_i  in  TEXT_ADDR_WIDTH  text RAM address of column 0
- glyph_row_i  in  4  glyph row (0..15) of this scanline
- busy_o  out  1  fetch in progress
- done_o  out  1  one-cycle pulse: line complete
- text_en_o  out  1  text RAM read enable
- text_addr_o  out  TEXT_ADDR_WIDTH  text RAM read address (registered)
- text_data_i  in  8  character code, valid 1 cycle after text_addr_o
- rom_addr_o  out  12  to character ROM addr_i
- rom_data_i  in  32  from character ROM data_o, valid 1 cycle after rom_addr_o
- lb_we_o  out  1  line buffer write enable
- lb_addr_o  out  7  line buffer column
- lb_data_o  out  32  glyph row pixels
- cpu_req_i  in  1  CPU glyph read request (held until ack)
- cpu_addr_i  in  12  CPU ROM address
- cpu_ack_o  out  1  one-cycle pulse: cpu_data_o valid
- cpu_data_o  out  32  CPU read data

Behaviour:
- Reset: state IDLE; all pipeline valids 0; busy_o, done_o, text_en_o, lb_we_o, cpu_ack_o = 0; all address/data outputs = 0. Reset mid-fetch discards everything, with no further writes.
- FSM states:
  - IDLE: start_i=1 latches base, row and col=0 → FETCH.
  - FETCH: issue text_addr_o = (base+col) mod 2^TEXT_ADDR_WIDTH, text_en_o=1, col++ each cycle. After col=COLUMNS-1 is issued → DRAIN.
  - DRAIN: wait for the pipeline to empty. Pulse done_o, then → IDLE.
- busy_o=1 in FETCH and DRAIN. start_i while busy is ignored.
- Pipeline, one column per cycle, no stalls:
  - S1 (text data valid): rom_addr_o = {text_data_i, row}, combinational.
  - S2 (ROM data valid): lb_we_o=1, lb_addr_o = column tag, lb_data_o = rom_data_i.
- Timing (start sampled at edge 0):
  - text_addr_o for col 0 valid in cycle 1.
  - First lb_we_o in cycle 3; last in cycle COLUMNS+2.
  - done_o in cycle COLUMNS+3, with busy_o dropping the same cycle.
- Column tags travel with the pipeline valid bits. Columns are written in strictly ascending order, with no gaps and no duplicates.
- ROM arbitration:
  - Video S1 has absolute priority.
  - If S1 is not valid and cpu_req_i=1 with no CPU read outstanding, grant: rom_addr_o = cpu_addr_i.
  - Next cycle: cpu_ack_o=1 and cpu_data_o = rom_data_i, held until the next ack.
  - Only one CPU read is outstanding at a time. The CPU must drop or change its request after ack; the same cycle as ack is not re-granted.
  - Worst-case CPU wait is COLUMNS+1 cycles.
- With no grant and S1 invalid, rom_addr_o holds its last value.
- abort_i=1:
  - Same cycle: clear FETCH issue and the S1/S2 valids, so lb_we_o=0 from this cycle onward.
  - Next cycle: state IDLE, busy_o=0.
  - No done_o pulse. An in-flight CPU read still completes.
  - abort_i together with start_i in IDLE: the start is ignored.
- Column counter and tag are 7 bits. Base addition wraps silently.
- The ROM's active-high reset input is driven outside this block and is not this block's concern.

Decomposition:
- Package additions:
  - CHAR_CODE_WIDTH=8, GLYPH_ROW_WIDTH=4, GLYPH_ADDR_WIDTH=12.
  - typedef glyph_addr_t packed struct {code, row}.
  - typedef fetch_state_t enum {IDLE, FETCH, DRAIN}.
- One natural sub-module: glyph_rom_arbiter, holding the priority mux plus CPU outstanding/ack logic. The FSM and pipeline stay in glyph_row_fetcher.

Test Plan:
- Line fetch: text RAM model with codes = column index, base=0x100, row=5, COLUMNS=80 → 80 writes, lb_addr 0..79 at cycles 3..82. lb_data = ROM[{col,5}]. done_o at cycle 83.
- Wrap: base=0xFFE, COLUMNS=4 → text addresses 0xFFE, 0xFFF, 0x000, 0x001 and 4 correct writes.
- CPU read while idle: cpu_req, addr=0xA53 → cpu_ack_o one cycle after grant, data=ROM[0xA53]. Hold req after ack → next grant no earlier than the following cycle.
- CPU contention: req asserted in cycle 2 of an 80-column fetch → no grant while S1 valid. Grant in the first free slot (cycle 82). Video writes unaffected.
- Abort at cycle 10 → lb_we_o=0 from cycle 10, busy_o=0 at cycle 11, no done_o. A new start at cycle 12 produces a full correct line.
- Reset mid-fetch at cycle 20 → all outputs 0 immediately (async). After release, the first start behaves as in the first scenario.
